timer_compare_irq: RTL and testbench

- Memory-mapped compare/interrupt unit sitting directly downstream of the system timer.
- Consumes the free-running 32-bit timer count and compares it against a programmable compare value.
- On a match it latches a pending flag and drives a level interrupt to the CPU.
- Supports one-shot and periodic (auto-advance) modes, with a 3-state arming FSM.

---
 rtl/timer_compare_irq_if.sv | 21 ++
 rtl/timer_compare_irq.sv | 116 +++++++++++
 tb/tb_timer_compare_irq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_compare_irq_if.sv
// Register bus between the CPU and the timer compare/interrupt unit.
// write/read are single-cycle strobes with no backpressure; readData is valid in the same cycle as read.
interface timer_compare_irq_if #(
  parameter int DATA_W = 32
);
  logic              write;
  logic              read;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic [3:0]        address;

  modport master (
    output write, read, writeData, address,
    input  readData
  );

  modport slave (
    input  write, read, writeData, address,
    output readData
  );
endinterface

// File: rtl/timer_compare_irq.sv
// Timer compare unit: wrap-safe match against COMPARE, one-shot/periodic arming FSM, level irq.
// Optional TIMER_COMPARE_MISS_COUNT_EN adds a saturating miss counter at STATUS[15:8].
module timer_compare_irq #(
  parameter int TIMER_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TIMER_WIDTH-1:0] timerValue,
  timer_compare_irq_if.slave     bus,
  output logic                   irq,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             ctrl_q;
  logic [TIMER_WIDTH-1:0] compare_q;
  logic [TIMER_WIDTH-1:0] period_q;
  logic                   pending_q;

  logic                   ctrl_wr, cmp_wr, per_wr, stat_wr;
  logic [TIMER_WIDTH-1:0] diff;
  logic [TIMER_WIDTH-1:0] eff_period;
  logic                   match, fire, w1c;
  logic [7:0]             miss_field;
  logic [31:0]            status_word;
  logic [31:0]            rdata;

  assign ctrl_wr = bus.write && (bus.address == 4'h0);
  assign cmp_wr  = bus.write && (bus.address == 4'h4);
  assign per_wr  = bus.write && (bus.address == 4'h8);
  assign stat_wr = bus.write && (bus.address == 4'hC);
  assign w1c     = stat_wr && bus.writeData[0];

  // Top bit of the modular difference clear means timer is at or up to half a wrap past compare.
  assign diff       = timerValue - compare_q;
  assign match      = ~diff[TIMER_WIDTH-1];
  assign fire       = (state_q == ST_ARMED) && match;
  assign eff_period = (period_q == '0) ? TIMER_WIDTH'(1) : period_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ctrl_wr && bus.writeData[0]) state_d = ST_ARMED;
      ST_ARMED: if (fire && !ctrl_q[1])          state_d = ST_DONE;
      ST_DONE:  if (cmp_wr && ctrl_q[0])         state_d = ST_ARMED;
      default:                                   state_d = ST_IDLE;
    endcase
    if (ctrl_wr && !bus.writeData[0]) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      compare_q <= '0;
      period_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ctrl_wr) ctrl_q   <= bus.writeData[2:0];
      if (per_wr)  period_q <= bus.writeData[TIMER_WIDTH-1:0];
      // A bus write to COMPARE takes priority over the periodic auto-advance.
      if (cmp_wr)
        compare_q <= bus.writeData[TIMER_WIDTH-1:0];
      else if (fire && ctrl_q[1])
        compare_q <= compare_q + eff_period;
      if (fire)
        pending_q <= 1'b1;
      else if (w1c)
        pending_q <= 1'b0;
    end
  end

`ifdef TIMER_COMPARE_MISS_COUNT_EN
  logic [7:0] miss_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      miss_q <= '0;
    else if (stat_wr && bus.writeData[8])
      miss_q <= '0;
    else if (fire && pending_q && !w1c && (miss_q != 8'hFF))
      miss_q <= miss_q + 8'd1;
  end

  assign miss_field = miss_q;
`else
  assign miss_field = 8'h00;
`endif

  assign status_word = {16'h0000, miss_field, 5'b00000, state_q, pending_q};

  always_comb begin
    rdata = '0;
    if (bus.read) begin
      case (bus.address)
        4'h0:    rdata = {29'b0, ctrl_q};
        4'h4:    rdata = 32'(compare_q);
        4'h8:    rdata = 32'(period_q);
        4'hC:    rdata = status_word;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.readData = rdata;
  assign irq          = pending_q & ctrl_q[2];
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_timer_compare_irq.sv
// Randomized + directed bench for timer_compare_irq: reference model feeds expected queues,
// a negedge monitor pops and compares bus reads and the irq/state outputs.
module tb_timer_compare_irq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] timerValue = '0;
  logic        irq;
  logic [1:0]  dbg_state;

  timer_compare_irq_if #(.DATA_W(32)) bus ();

  timer_compare_irq #(.TIMER_WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .timerValue (timerValue),
    .bus        (bus),
    .irq        (irq),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [2:0]  exp_sig_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]  m_ctrl;
  logic [31:0] m_cmp, m_per;
  logic        m_pend;
  int          m_state;   // 0 idle, 1 armed, 2 done
  int          m_miss;

  logic        cur_wr, cur_rd;
  logic [3:0]  cur_addr;
  logic [31:0] cur_wd;
  logic [31:0] cur_tv;
  logic [31:0] tv;

  function automatic void model_reset();
    m_ctrl = '0; m_cmp = '0; m_per = '0; m_pend = 1'b0; m_state = 0; m_miss = 0;
  endfunction

  function automatic void model_step();
    logic        c_w, k_w, p_w, s_w, hit, clr;
    logic [31:0] step;
    int          nstate;
    c_w  = cur_wr && cur_addr == 4'h0;
    k_w  = cur_wr && cur_addr == 4'h4;
    p_w  = cur_wr && cur_addr == 4'h8;
    s_w  = cur_wr && cur_addr == 4'hC;
    clr  = s_w && cur_wd[0];
    hit  = (m_state == 1) && ((cur_tv - m_cmp) < 32'h8000_0000);
    step = (m_per == 0) ? 32'd1 : m_per;
    nstate = m_state;
    if (m_state == 0 && c_w && cur_wd[0]) nstate = 1;
    if (m_state == 1 && hit && !m_ctrl[1]) nstate = 2;
    if (m_state == 2 && k_w && m_ctrl[0]) nstate = 1;
    if (c_w && !cur_wd[0]) nstate = 0;
`ifdef TIMER_COMPARE_MISS_COUNT_EN
    if (s_w && cur_wd[8]) m_miss = 0;
    else if (hit && m_pend && !clr && m_miss < 255) m_miss = m_miss + 1;
`endif
    if (k_w) m_cmp = cur_wd;
    else if (hit && m_ctrl[1]) m_cmp = m_cmp + step;
    if (hit) m_pend = 1'b1;
    else if (clr) m_pend = 1'b0;
    if (p_w) m_per = cur_wd;
    if (c_w) m_ctrl = cur_wd[2:0];
    m_state = nstate;
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] v;
    logic [1:0]  st;
    st = 2'(m_state);
    case (a)
      4'h0:    v = {29'b0, m_ctrl};
      4'h4:    v = m_cmp;
      4'h8:    v = m_per;
      4'hC:    v = {16'h0, 8'(m_miss), 5'b0, st, m_pend};
      default: v = '0;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic wr, input logic rd, input logic [3:0] addr,
                       input logic [31:0] wd, input logic use_exp, input logic [31:0] exp_val);
    logic [1:0] st;
    @(posedge clk);
    model_step();
    #1;
    bus.write = wr; bus.read = rd; bus.address = addr; bus.writeData = wd; timerValue = tv;
    cur_wr = wr; cur_rd = rd; cur_addr = addr; cur_wd = wd; cur_tv = tv;
    st = 2'(m_state);
    exp_sig_q.push_back({st, m_pend & m_ctrl[2]});
    if (rd) exp_q.push_back(use_exp ? exp_val : model_read(addr));
    tv = tv + 1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d); cycle(1'b1, 1'b0, a, d, 1'b0, '0); endtask
  task automatic rd(input logic [3:0] a);                       cycle(1'b0, 1'b1, a, '0, 1'b0, '0); endtask
  task automatic rd_expect(input logic [3:0] a, input logic [31:0] v); cycle(1'b0, 1'b1, a, '0, 1'b1, v); endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic async_reset_pulse();
    @(posedge clk);
    model_step();
    #1;
    bus.write = 1'b0; bus.read = 1'b0; bus.address = 4'h0; bus.writeData = '0;
    cur_wr = 1'b0; cur_rd = 1'b0; cur_addr = 4'h0; cur_wd = '0;
    #2;
    reset = 1'b1; bus.read = 1'b1; bus.address = 4'hC;
    #1;
    check("async_rst_irq", {31'b0, irq}, 32'h0);
    check("async_rst_status", bus.readData, 32'h0);
    bus.read = 1'b0; reset = 1'b0;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2:0] es;
    if (exp_sig_q.size() > 0) begin
      es = exp_sig_q.pop_front();
      check("irq", {31'b0, irq}, {31'b0, es[0]});
      check("state", {30'b0, dbg_state}, {30'b0, es[2:1]});
    end
    if (bus.read) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_underflow: read at %0t with no expected value queued", $time);
      end else begin
        check("readData", bus.readData, exp_q.pop_front());
      end
    end else begin
      check("rd_idle", bus.readData, 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int sel;
    logic [3:0] a;
    logic [31:0] d;
    bus.write = 1'b0; bus.read = 1'b0; bus.address = '0; bus.writeData = '0;
    cur_wr = 1'b0; cur_rd = 1'b0; cur_addr = '0; cur_wd = '0; cur_tv = '0; tv = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset values
    rd_expect(4'h0, 32'h0); rd_expect(4'h4, 32'h0); rd_expect(4'h8, 32'h0);
    rd_expect(4'hC, 32'h0); rd_expect(4'h6, 32'h0);

    // one-shot
    tv = 32'hF0;
    wr(4'h4, 32'h100);
    wr(4'h0, 32'h5);
    while (tv <= 32'h112) rd(4'hC);
    rd_expect(4'hC, 32'h5);
    rd_expect(4'h4, 32'h100);

    // periodic with W1C on each fire
    tv = 32'h0;
    wr(4'h0, 32'h0); wr(4'hC, 32'h1);
    wr(4'h4, 32'h10); wr(4'h8, 32'h20);
    wr(4'h0, 32'h7);
    while (tv < 32'h60) begin
      if (m_pend) wr(4'hC, 32'h1);
      else rd(4'hC);
    end
    rd_expect(4'h4, 32'h70);
    wr(4'h0, 32'h0);

    // wrap
    wr(4'hC, 32'h1);
    tv = 32'hFFFF_FFF0;
    wr(4'h4, 32'h5);
    wr(4'h0, 32'h5);
    repeat (32) rd(4'hC);
    rd_expect(4'hC, 32'h5);

    // set wins over W1C; irqEn gating
    wr(4'h0, 32'h0); wr(4'hC, 32'h1); wr(4'h8, 32'h0);
    wr(4'h4, tv);
    wr(4'h0, 32'h3);
    repeat (3) rd(4'hC);
    wr(4'hC, 32'h1);
    rd_expect(4'hC, 32'h3);
    wr(4'h0, 32'h7);
    repeat (3) rd(4'hC);

    // disable while armed
    wr(4'h0, 32'h0); wr(4'hC, 32'h1);
    wr(4'h4, tv + 32'h100);
    wr(4'h0, 32'h5);
    repeat (3) rd(4'hC);
    wr(4'h0, 32'h0);
    rd_expect(4'hC, 32'h0);

    // async reset while pending
    wr(4'h4, tv + 32'h3);
    wr(4'h0, 32'h5);
    repeat (6) rd(4'hC);
    async_reset_pulse();
    rd_expect(4'h0, 32'h0); rd_expect(4'h4, 32'h0); rd_expect(4'hC, 32'h0);

`ifdef TIMER_COMPARE_MISS_COUNT_EN
    wr(4'h8, 32'h1);
    wr(4'h4, tv);
    wr(4'h0, 32'h3);
    repeat (270) rd(4'hC);
    rd_expect(4'hC, 32'h0000_FF03);
    wr(4'hC, 32'h100);
    rd_expect(4'hC, 32'h0000_0003);
    wr(4'h0, 32'h0);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      a = (sel == 9) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3) * 4);
      case (a)
        4'h0:    d = $urandom();
        4'h4:    d = tv + $urandom_range(0, 48);
        4'h8:    d = $urandom_range(0, 12);
        4'hC:    d = $urandom_range(0, 511);
        default: d = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) tv = tv + $urandom_range(0, 20);
      if (sel < 3)      wr(a, d);
      else if (sel < 8) rd(a);
      else              cycle(1'b0, 1'b0, 4'h0, '0, 1'b0, '0);
    end

    repeat (2) cycle(1'b0, 1'b0, 4'h0, '0, 1'b0, '0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 32'h0);
    check("exp_sig_q_drained", exp_sig_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2000000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
